// File: rtl/sfpp_link_supervisor.sv
// SFP+ link supervisor: per-channel lock FSMs with automatic RX datapath
// reset recovery, drop/reset counters and a Wishbone control/status slave.
module sfpp_link_supervisor #(
    parameter int N_CHANNELS   = 2,
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int LOSS_FILTER  = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CHANNELS-1:0] rx_block_lock,
    input  logic [N_CHANNELS-1:0] rx_high_ber,
    output logic [N_CHANNELS-1:0] rx_datapath_reset,
    output logic [N_CHANNELS-1:0] loopback,
    output logic [N_CHANNELS-1:0] link_up,
    output logic                  irq,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [7:0]            wb_adr,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack
);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_UP    = 2'd2;
    localparam logic [1:0] ST_DIS   = 2'd3;

    localparam int TMAX = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(LOSS_FILTER + 1);

    localparam logic [TW-1:0]        RST_LAST  = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0]        LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [BW-1:0]        BAD_LAST  = BW'(LOSS_FILTER - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    logic [1:0]           state     [N_CHANNELS];
    logic [1:0]           state_nxt [N_CHANNELS];
    logic [TW-1:0]        timer     [N_CHANNELS];
    logic [BW-1:0]        bad_cnt   [N_CHANNELS];
    logic [CNT_WIDTH-1:0] drop_cnt  [N_CHANNELS];
    logic [CNT_WIDTH-1:0] reset_cnt [N_CHANNELS];

    logic [N_CHANNELS-1:0] sticky;
    logic [N_CHANNELS-1:0] enable;
    logic [N_CHANNELS-1:0] bad;
    logic [N_CHANNELS-1:0] en_nxt;
    logic [N_CHANNELS-1:0] force_rst;
    logic [N_CHANNELS-1:0] drop_inc;
    logic [N_CHANNELS-1:0] rst_inc;
    logic [N_CHANNELS-1:0] wr_ctrl;
    logic [N_CHANNELS-1:0] wr_status;
    logic [N_CHANNELS-1:0] wr_drop;
    logic [N_CHANNELS-1:0] wr_rstc;

    logic        req;
    logic        wr;
    logic [31:0] rdata;
    logic        unused_dat;

    assign req = wb_cyc & wb_stb & ~wb_ack;
    assign wr  = req & wb_we;
    assign bad = ~rx_block_lock | rx_high_ber;

    assign unused_dat = ^{wb_dat_i[31:5], wb_dat_i[3]};

    always_comb begin
        for (int c = 0; c < N_CHANNELS; c++) begin
            wr_ctrl[c]   = wr && (wb_adr == {4'(c + 1), 4'h0});
            wr_status[c] = wr && (wb_adr == {4'(c + 1), 4'h4});
            wr_drop[c]   = wr && (wb_adr == {4'(c + 1), 4'h8});
            wr_rstc[c]   = wr && (wb_adr == {4'(c + 1), 4'hC});
        end
    end

    // A CTRL write acts on the FSM at the same edge that acks it.
    always_comb begin
        for (int c = 0; c < N_CHANNELS; c++) begin
            en_nxt[c]    = wr_ctrl[c] ? wb_dat_i[0] : enable[c];
            force_rst[c] = wr_ctrl[c] & wb_dat_i[1];
            state_nxt[c] = state[c];
            drop_inc[c]  = 1'b0;
            rst_inc[c]   = 1'b0;
            if (!en_nxt[c]) begin
                state_nxt[c] = ST_DIS;
            end else if (state[c] == ST_DIS) begin
                state_nxt[c] = ST_RESET;
            end else if (force_rst[c]) begin
                state_nxt[c] = ST_RESET;
                rst_inc[c]   = 1'b1;
            end else begin
                case (state[c])
                    ST_RESET: begin
                        if (timer[c] == RST_LAST) state_nxt[c] = ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (!bad[c]) begin
                            state_nxt[c] = ST_UP;
                        end else if (timer[c] == LOCK_LAST) begin
                            state_nxt[c] = ST_RESET;
                            rst_inc[c]   = 1'b1;
                        end
                    end
                    ST_UP: begin
                        if (bad[c] && bad_cnt[c] == BAD_LAST) begin
                            state_nxt[c] = ST_RESET;
                            drop_inc[c]  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                state[c]     <= ST_RESET;
                timer[c]     <= '0;
                bad_cnt[c]   <= '0;
                drop_cnt[c]  <= '0;
                reset_cnt[c] <= '0;
            end
            sticky            <= '0;
            enable            <= '1;
            loopback          <= '0;
            rx_datapath_reset <= '1;
            link_up           <= '0;
            irq               <= 1'b0;
        end else begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                state[c] <= state_nxt[c];
                if (state_nxt[c] != state[c] || state[c] == ST_UP || state[c] == ST_DIS)
                    timer[c] <= '0;
                else
                    timer[c] <= timer[c] + 1'b1;
                if (state[c] == ST_UP && state_nxt[c] == ST_UP && bad[c])
                    bad_cnt[c] <= bad_cnt[c] + 1'b1;
                else
                    bad_cnt[c] <= '0;
                if (wr_drop[c])
                    drop_cnt[c] <= '0;
                else if (drop_inc[c] && drop_cnt[c] != CNT_MAX)
                    drop_cnt[c] <= drop_cnt[c] + 1'b1;
                if (wr_rstc[c])
                    reset_cnt[c] <= '0;
                else if (rst_inc[c] && reset_cnt[c] != CNT_MAX)
                    reset_cnt[c] <= reset_cnt[c] + 1'b1;
                if (wr_status[c] && wb_dat_i[4])
                    sticky[c] <= 1'b0;
                else if (drop_inc[c])
                    sticky[c] <= 1'b1;
                if (wr_ctrl[c])
                    loopback[c] <= wb_dat_i[2];
                enable[c]            <= en_nxt[c];
                rx_datapath_reset[c] <= (state_nxt[c] == ST_RESET);
                link_up[c]           <= (state_nxt[c] == ST_UP);
            end
            irq <= |sticky;
        end
    end

    always_comb begin
        rdata = '0;
        if (wb_adr == 8'h00)
            rdata = {16'h5346, 8'h00, 8'(N_CHANNELS)};
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (wb_adr[7:4] == 4'(c + 1)) begin
                case (wb_adr[3:0])
                    4'h0: rdata = {29'd0, loopback[c], 1'b0, enable[c]};
                    4'h4: rdata = {27'd0, sticky[c], state[c],
                                   rx_high_ber[c], rx_block_lock[c]};
                    4'h8: rdata = 32'(drop_cnt[c]);
                    4'hC: rdata = 32'(reset_cnt[c]);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack   <= req;
            wb_dat_o <= req ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_sfpp_link_supervisor.sv
// Directed bench for sfpp_link_supervisor; a second CNT_WIDTH=4 instance
// shares all inputs to show counter saturation.
module tb_sfpp_link_supervisor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rx_block_lock = 2'b11;
    logic [1:0]  rx_high_ber = 2'b00;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [7:0]  wb_adr = 8'h00;
    logic [31:0] wb_dat_i = 32'h0;

    logic [1:0]  rx_datapath_reset, loopback, link_up;
    logic        irq, wb_ack;
    logic [31:0] wb_dat_o;
    logic [1:0]  rx2, lp2, lu2;
    logic        irq2, ack2;
    logic [31:0] dat2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sfpp_link_supervisor dut (
        .clk(clk), .rst_n(rst_n),
        .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
        .rx_datapath_reset(rx_datapath_reset), .loopback(loopback),
        .link_up(link_up), .irq(irq),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack(wb_ack)
    );

    sfpp_link_supervisor #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber),
        .rx_datapath_reset(rx2), .loopback(lp2),
        .link_up(lu2), .irq(irq2),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_dat_o(dat2), .wb_ack(ack2)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [31:0] d);
        bit got = 0;
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = adr; wb_dat_i = d;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            got = wb_ack;
        end
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wr_ack adr=%h: no ack, required ack", adr);
        end
    endtask

    task automatic wb_read(input logic [7:0] adr,
                           output logic [31:0] d, output logic [31:0] d4);
        bit got = 0;
        d = '1; d4 = '1;
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = adr;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            got = wb_ack;
            if (got) begin d = wb_dat_o; d4 = dat2; end
        end
        wb_cyc = 0; wb_stb = 0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rd_ack adr=%h: no ack, required ack", adr);
        end
    endtask

    task automatic wait_up(input int ch, input int budget);
        for (int i = 0; i < budget && !link_up[ch]; i++) tick(1);
        checks++;
        if (link_up[ch] !== 1'b1) begin
            errors++;
            $display("FAIL wait_up ch%0d: link_up=%b, required 1", ch, link_up[ch]);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d, d4;
        tick(3);
        checks++;
        if (rx_datapath_reset !== 2'b11 || link_up !== 2'b00 || loopback !== 2'b00
            || irq !== 1'b0 || wb_ack !== 1'b0 || wb_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_vals: rst=%b up=%b lb=%b irq=%b ack=%b dat=%h",
                     rx_datapath_reset, link_up, loopback, irq, wb_ack, wb_dat_o);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            checks++;
            if (rx_datapath_reset !== ((k < 16) ? 2'b11 : 2'b00)
                || link_up !== ((k >= 17) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL powerup edge %0d: rst=%b up=%b", k, rx_datapath_reset, link_up);
            end
        end
        wb_read(8'h14, d, d4);
        checks++;
        if (d !== 32'h9) begin errors++; $display("FAIL status_up: got %h, required 9", d); end
        wb_read(8'h18, d, d4);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL drop0: got %h, required 0", d); end
        wb_read(8'h1C, d, d4);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rstcnt0: got %h, required 0", d); end
        wb_read(8'h00, d, d4);
        checks++;
        if (d !== 32'h53460002) begin errors++; $display("FAIL id: got %h, required 53460002", d); end
        wb_read(8'h80, d, d4);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped: got %h, required 0", d); end
    endtask

    task automatic test_loss_filter;
        logic [31:0] d, d4;
        rx_high_ber[0] = 1'b1;
        tick(3);
        checks++;
        if (link_up[0] !== 1'b1) begin errors++; $display("FAIL ber3_up: got %b, required 1", link_up[0]); end
        rx_high_ber[0] = 1'b0;
        tick(1);
        wb_read(8'h18, d, d4);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL drop_after3: got %h, required 0", d); end
        rx_block_lock[0] = 1'b0;
        tick(3);
        checks++;
        if (link_up[0] !== 1'b1) begin errors++; $display("FAIL lock3_up: got %b, required 1", link_up[0]); end
        tick(1);
        checks++;
        if (link_up[0] !== 1'b0 || rx_datapath_reset[0] !== 1'b1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL drop4: up=%b rst=%b irq=%b, required 0 1 0",
                     link_up[0], rx_datapath_reset[0], irq);
        end
        rx_block_lock[0] = 1'b1;
        tick(1);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b, required 1", irq); end
        wb_read(8'h14, d, d4);
        checks++;
        if (d !== 32'h11) begin errors++; $display("FAIL status_drop: got %h, required 11", d); end
        wb_read(8'h18, d, d4);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL drop1: got %h, required 1", d); end
        wb_write(8'h14, 32'h10);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b, required 1", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b, required 0", irq); end
        wait_up(0, 40);
        checks++;
        if (link_up[1] !== 1'b1) begin errors++; $display("FAIL ch1_steady: got %b, required 1", link_up[1]); end
    endtask

    task automatic test_timeout;
        logic [31:0] d, d4;
        wb_write(8'h20, 32'h0);
        rx_block_lock[1] = 1'b0;
        wb_write(8'h28, 32'h0);
        wb_write(8'h2C, 32'h0);
        wb_write(8'h20, 32'h1);
        tick(1039);
        checks++;
        if (rx_datapath_reset[1] !== 1'b0) begin errors++; $display("FAIL to_pre: got %b, required 0", rx_datapath_reset[1]); end
        tick(1);
        checks++;
        if (rx_datapath_reset[1] !== 1'b1) begin errors++; $display("FAIL to_fire: got %b, required 1", rx_datapath_reset[1]); end
        wb_read(8'h2C, d, d4);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL rstcnt1: got %h, required 1", d); end
        tick(2077);
        wb_read(8'h2C, d, d4);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL rstcnt2: got %h, required 2", d); end
        tick(1);
        wb_read(8'h2C, d, d4);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL rstcnt3: got %h, required 3", d); end
        wb_read(8'h28, d, d4);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ch1_drop: got %h, required 0", d); end
        checks++;
        if (link_up[0] !== 1'b1) begin errors++; $display("FAIL ch0_isolated: got %b, required 1", link_up[0]); end
        wb_read(8'h1C, d, d4);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ch0_rstcnt: got %h, required 0", d); end
        wb_read(8'h18, d, d4);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL ch0_drop: got %h, required 1", d); end
        rx_block_lock[1] = 1'b1;
        wait_up(1, 1100);
    endtask

    task automatic test_clear_collision;
        logic [31:0] d, d4;
        rx_block_lock[0] = 1'b0;
        tick(3);
        wb_write(8'h18, 32'h0);
        rx_block_lock[0] = 1'b1;
        checks++;
        if (link_up[0] !== 1'b0) begin errors++; $display("FAIL coll_drop: up=%b, required 0", link_up[0]); end
        wb_read(8'h18, d, d4);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL coll_cnt: got %h, required 0", d); end
        wb_write(8'h14, 32'h10);
        wait_up(0, 40);
    endtask

    task automatic test_ctrl;
        logic [31:0] d, d4;
        wb_write(8'h10, 32'h0);
        checks++;
        if (link_up[0] !== 1'b0 || rx_datapath_reset[0] !== 1'b0) begin
            errors++;
            $display("FAIL dis_entry: up=%b rst=%b, required 0 0", link_up[0], rx_datapath_reset[0]);
        end
        for (int k = 0; k < 20; k++) begin
            tick(1);
            checks++;
            if (rx_datapath_reset[0] !== 1'b0) begin errors++; $display("FAIL dis_nopulse %0d: got 1, required 0", k); end
        end
        wb_read(8'h14, d, d4);
        checks++;
        if (d !== 32'hD) begin errors++; $display("FAIL status_dis: got %h, required d", d); end
        wb_write(8'h10, 32'h1);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (rx_datapath_reset[0] !== 1'b1) begin errors++; $display("FAIL en_pulse %0d: got 0, required 1", k); end
            tick(1);
        end
        checks++;
        if (rx_datapath_reset[0] !== 1'b0) begin errors++; $display("FAIL en_pulse_end: got 1, required 0"); end
        tick(1);
        checks++;
        if (link_up[0] !== 1'b1) begin errors++; $display("FAIL en_up: got %b, required 1", link_up[0]); end
        wb_write(8'h10, 32'h3);
        checks++;
        if (link_up[0] !== 1'b0 || rx_datapath_reset[0] !== 1'b1) begin
            errors++;
            $display("FAIL force: up=%b rst=%b, required 0 1", link_up[0], rx_datapath_reset[0]);
        end
        wb_read(8'h1C, d, d4);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL force_cnt: got %h, required 1", d); end
        wb_read(8'h10, d, d4);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL ctrl_rd: got %h, required 1", d); end
        wb_write(8'h10, 32'h5);
        checks++;
        if (loopback !== 2'b01) begin errors++; $display("FAIL loopback: got %b, required 01", loopback); end
        wb_read(8'h10, d, d4);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL ctrl_lb: got %h, required 5", d); end
    endtask

    task automatic test_saturation;
        logic [31:0] d, d4;
        for (int n = 0; n < 20; n++) begin
            wait_up(0, 40);
            rx_block_lock[0] = 1'b0;
            tick(4);
            rx_block_lock[0] = 1'b1;
        end
        wb_read(8'h18, d, d4);
        checks++;
        if (d !== 32'd20) begin errors++; $display("FAIL drop20: got %0d, required 20", d); end
        checks++;
        if (d4 !== 32'd15) begin errors++; $display("FAIL drop_sat: got %0d, required 15", d4); end
    endtask

    task automatic test_async_reset;
        logic [31:0] d, d4;
        tick(5);
        checks++;
        if (rx_datapath_reset[0] !== 1'b1 || loopback[0] !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst: rst=%b lb=%b irq=%b, required 1 1 1",
                     rx_datapath_reset[0], loopback[0], irq);
        end
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rx_datapath_reset !== 2'b11 || link_up !== 2'b00 || loopback !== 2'b00
            || irq !== 1'b0 || wb_ack !== 1'b0 || wb_dat_o !== 32'h0 || rx2 !== 2'b11) begin
            errors++;
            $display("FAIL async_rst: rst=%b up=%b lb=%b irq=%b ack=%b dat=%h",
                     rx_datapath_reset, link_up, loopback, irq, wb_ack, wb_dat_o);
        end
        tick(1);
        checks++;
        if (wb_ack !== 1'b0) begin errors++; $display("FAIL rst_noack: got 1, required 0"); end
        wb_cyc = 0; wb_stb = 0;
        rst_n = 1'b1;
        tick(1);
        wb_read(8'h18, d, d4);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_drop: got %h, required 0", d); end
        wb_read(8'h10, d, d4);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL rst_ctrl: got %h, required 1", d); end
    endtask

    initial begin
        test_reset();
        test_loss_filter();
        test_timeout();
        test_clear_collision();
        test_ctrl();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
